// File: rtl/spi_transaction_fsm.sv
// ---------------------------------------------------------------------------
// spi_transaction_fsm
//   Control FSM for an SPI slave. It sequences one transaction: it collects
//   the address/R-W field, latches the address, and then either loads and
//   shifts out a read word or collects a write word and commits it to memory.
//   All outputs are Moore outputs decoded from the registered state.
//
//   A high chip select in any non-IDLE state aborts the transaction and
//   returns to IDLE on the next cycle. This abort takes priority over every
//   other transition.
//
// Parameters
//   width        bits per SPI field (address+R/W field and data field)
//
// Ports
//   clk          FPGA clock; all state changes occur on posedge clk
//   reset        synchronous, active-high reset
//   cs           conditioned chip select, active low
//   sclkPosEdge  one-clk pulse per SCLK rising edge
//   sclkNegEdge  one-clk pulse per SCLK falling edge
//   rwBit        shift-register bit 0 after the address field (1 = read)
//   srLoad       shift-register parallel-load strobe
//   addrWE       address-latch write enable
//   dmWE         data-memory write enable
//   misoBufE     MISO tri-state buffer enable
//   busy         high whenever the FSM is not in IDLE
//   abortErr     (only with SPI_FSM_ABORT_ERR_EN) one-cycle pulse following
//                an abort from any state other than IDLE or DONE
//
// Build option
//   SPI_FSM_ABORT_ERR_EN  adds the abortErr output and the logic behind it.
// ---------------------------------------------------------------------------
module spi_transaction_fsm #(
  parameter int width = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclkPosEdge,
  input  logic sclkNegEdge,
  input  logic rwBit,
  output logic srLoad,
  output logic addrWE,
  output logic dmWE,
  output logic misoBufE,
  output logic busy
`ifdef SPI_FSM_ABORT_ERR_EN
  ,
  output logic abortErr
`endif
);

  localparam int CNT_W = $clog2(width + 1);
  // The terminal pulse arrives while the counter still holds width-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(width - 1);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GOT_ADDR,
    READ_LOAD,
    READ_SHIFT,
    WRITE_GET,
    WRITE_MEM,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    srLoad     = 1'b0;
    addrWE     = 1'b0;
    dmWE       = 1'b0;
    misoBufE   = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE: begin
        if (!cs) state_next = GET_ADDR;
      end
      GET_ADDR: begin
        if (sclkPosEdge) begin
          if (cnt == LAST) state_next = GOT_ADDR;
          else             cnt_next   = cnt + 1'b1;
        end
      end
      GOT_ADDR: begin
        addrWE     = 1'b1;
        state_next = rwBit ? READ_LOAD : WRITE_GET;
      end
      READ_LOAD: begin
        srLoad     = 1'b1;
        state_next = READ_SHIFT;
      end
      READ_SHIFT: begin
        misoBufE = 1'b1;
        if (sclkNegEdge) begin
          if (cnt == LAST) state_next = DONE;
          else             cnt_next   = cnt + 1'b1;
        end
      end
      WRITE_GET: begin
        if (sclkPosEdge) begin
          if (cnt == LAST) state_next = WRITE_MEM;
          else             cnt_next   = cnt + 1'b1;
        end
      end
      WRITE_MEM: begin
        dmWE       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        // Hold until chip select rises; the abort path below handles that.
      end
      default: state_next = IDLE;
    endcase

    // Chip select high overrides every other transition, including a
    // terminal edge arriving in the same cycle.
    if (state != IDLE && cs) state_next = IDLE;

    // Every state starts counting from zero.
    if (state_next != state) cnt_next = '0;
  end

`ifdef SPI_FSM_ABORT_ERR_EN
  // Registered, so the pulse lands in the first IDLE cycle after the abort.
  always_ff @(posedge clk) begin
    if (reset) abortErr <= 1'b0;
    else       abortErr <= cs && (state != IDLE) && (state != DONE);
  end
`endif

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// ---------------------------------------------------------------------------
// tb_spi_transaction_fsm
//   Self-checking bench for spi_transaction_fsm (width = 8). A transaction
//   level reference model tracks the phase and the number of qualifying SCLK
//   edges seen, and every cycle the DUT outputs are compared against it.
//   Directed scenarios pin the model with hand-computed expectations, then a
//   randomized run exercises aborts, resets and noise pulses.
// ---------------------------------------------------------------------------
module tb_spi_transaction_fsm;

  localparam int W = 8;

  // Reference model phases.
  localparam int PH_IDLE  = 0;
  localparam int PH_ADDR  = 1;
  localparam int PH_LATCH = 2;
  localparam int PH_LOAD  = 3;
  localparam int PH_SHIFT = 4;
  localparam int PH_WDATA = 5;
  localparam int PH_COMMIT = 6;
  localparam int PH_END   = 7;

  logic clk = 1'b0;
  logic reset, cs, sclkPosEdge, sclkNegEdge, rwBit;
  logic srLoad, addrWE, dmWE, misoBufE, busy;
`ifdef SPI_FSM_ABORT_ERR_EN
  logic abortErr;
`endif

  int checks = 0;
  int failures = 0;

  // Observed strobe statistics (sampled mid-cycle).
  int n_addr = 0;
  int n_dm = 0;
  int n_sr = 0;
  int n_abort = 0;
  int n_neg_shift = 0;

  // Model state.
  int m_phase = PH_IDLE;
  int m_edges = 0;
  bit m_abort = 1'b0;

  spi_transaction_fsm #(.width(W)) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .sclkPosEdge(sclkPosEdge),
    .sclkNegEdge(sclkNegEdge),
    .rwBit(rwBit),
    .srLoad(srLoad),
    .addrWE(addrWE),
    .dmWE(dmWE),
    .misoBufE(misoBufE),
    .busy(busy)
`ifdef SPI_FSM_ABORT_ERR_EN
    ,
    .abortErr(abortErr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: advance one cycle from the inputs seen at this edge.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = PH_IDLE;
      m_edges = 0;
      m_abort = 1'b0;
    end else begin
      m_abort = cs && (m_phase != PH_IDLE) && (m_phase != PH_END);
      if (cs && m_phase != PH_IDLE) begin
        m_phase = PH_IDLE;
        m_edges = 0;
      end else if (m_phase == PH_IDLE) begin
        if (!cs) begin
          m_phase = PH_ADDR;
          m_edges = 0;
        end
      end else if (m_phase == PH_ADDR || m_phase == PH_WDATA) begin
        if (sclkPosEdge) m_edges = m_edges + 1;
        if (m_edges >= W) begin
          m_phase = (m_phase == PH_ADDR) ? PH_LATCH : PH_COMMIT;
          m_edges = 0;
        end
      end else if (m_phase == PH_SHIFT) begin
        if (sclkNegEdge) m_edges = m_edges + 1;
        if (m_edges >= W) begin
          m_phase = PH_END;
          m_edges = 0;
        end
      end else if (m_phase == PH_LATCH) begin
        m_phase = rwBit ? PH_LOAD : PH_WDATA;
      end else if (m_phase == PH_LOAD) begin
        m_phase = PH_SHIFT;
      end else if (m_phase == PH_COMMIT) begin
        m_phase = PH_END;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model mid-cycle,
  // then return 2 time units after the next rising edge.
  task automatic cyc(input bit p, input bit n);
    sclkPosEdge = p;
    sclkNegEdge = n;
    @(negedge clk);
    chk("busy",     int'(busy),     int'(m_phase != PH_IDLE));
    chk("addrWE",   int'(addrWE),   int'(m_phase == PH_LATCH));
    chk("srLoad",   int'(srLoad),   int'(m_phase == PH_LOAD));
    chk("misoBufE", int'(misoBufE), int'(m_phase == PH_SHIFT));
    chk("dmWE",     int'(dmWE),     int'(m_phase == PH_COMMIT));
`ifdef SPI_FSM_ABORT_ERR_EN
    chk("abortErr", int'(abortErr), int'(m_abort));
    if (abortErr === 1'b1) n_abort++;
`endif
    if (addrWE === 1'b1) n_addr++;
    if (dmWE === 1'b1) n_dm++;
    if (srLoad === 1'b1) n_sr++;
    if (sclkNegEdge && misoBufE === 1'b1) n_neg_shift++;
    @(posedge clk);
    #2;
  endtask

  // n edges of one kind separated by idle cycles; returns right after the
  // cycle in which the last pulse was sampled.
  task automatic pulses(input bit is_pos, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) cyc(1'b0, 1'b0);
      cyc(is_pos, !is_pos);
    end
  endtask

  int b_addr, b_dm, b_neg, b_abort;

  initial begin
    reset = 1'b1;
    cs = 1'b1;
    sclkPosEdge = 1'b0;
    sclkNegEdge = 1'b0;
    rwBit = 1'b0;
    @(posedge clk);
    #2;

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    cyc(1'b0, 1'b0);

    // Write transaction
    b_addr = n_addr; b_dm = n_dm;
    cs = 1'b0; rwBit = 1'b0;
    cyc(1'b0, 1'b0);
    chk("wr_start_busy", int'(busy), 1);
    pulses(1'b1, W);
    chk("wr_addrWE", int'(addrWE), 1);
    cyc(1'b0, 1'b0);
    chk("wr_addrWE_off", int'(addrWE), 0);
    pulses(1'b1, W);
    chk("wr_dmWE", int'(dmWE), 1);
    cyc(1'b0, 1'b0);
    chk("wr_dmWE_off", int'(dmWE), 0);
    chk("wr_done_busy", int'(busy), 1);
    // Noise in DONE
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b1); cyc(1'b1, 1'b0);
    chk("wr_noise_busy", int'(busy), 1);
    cs = 1'b1;
    cyc(1'b0, 1'b0);
    chk("wr_end_busy", int'(busy), 0);
    // Noise while deselected
    cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
    chk("cs_noise_busy", int'(busy), 0);
    chk("wr_addr_count", n_addr - b_addr, 1);
    chk("wr_dm_count", n_dm - b_dm, 1);

    // Read transaction
    b_addr = n_addr; b_dm = n_dm; b_neg = n_neg_shift;
    cs = 1'b0; rwBit = 1'b1;
    cyc(1'b0, 1'b0);
    pulses(1'b1, W);
    chk("rd_addrWE", int'(addrWE), 1);
    cyc(1'b0, 1'b0);
    chk("rd_srLoad", int'(srLoad), 1);
    cyc(1'b0, 1'b0);
    chk("rd_srLoad_off", int'(srLoad), 0);
    chk("rd_miso_on", int'(misoBufE), 1);
    pulses(1'b0, W + 2);
    chk("rd_miso_off", int'(misoBufE), 0);
    chk("rd_done_busy", int'(busy), 1);
    chk("rd_neg_count", n_neg_shift - b_neg, W);
    chk("rd_dm_count", n_dm - b_dm, 0);
    cs = 1'b1;
    cyc(1'b0, 1'b0);

    // Abort after three address edges
    b_addr = n_addr; b_dm = n_dm; b_abort = n_abort;
    cs = 1'b0; rwBit = 1'b0;
    cyc(1'b0, 1'b0);
    pulses(1'b1, 3);
    cs = 1'b1;
    cyc(1'b0, 1'b0);
    chk("abort_busy", int'(busy), 0);
`ifdef SPI_FSM_ABORT_ERR_EN
    chk("abort_err_pulse", int'(abortErr), 1);
`endif
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    chk("abort_addr_count", n_addr - b_addr, 0);
    chk("abort_dm_count", n_dm - b_dm, 0);
`ifdef SPI_FSM_ABORT_ERR_EN
    chk("abort_err_count", n_abort - b_abort, 1);
`endif

    // cs rises together with the final write-data edge
    b_dm = n_dm;
    cs = 1'b0; rwBit = 1'b0;
    cyc(1'b0, 1'b0);
    pulses(1'b1, W);
    cyc(1'b0, 1'b0);
    pulses(1'b1, W - 1);
    cyc(1'b0, 1'b0);
    cs = 1'b1;
    cyc(1'b1, 1'b0);
    chk("simul_busy", int'(busy), 0);
    chk("simul_dmWE", int'(dmWE), 0);
    cyc(1'b0, 1'b0);
    chk("simul_dm_count", n_dm - b_dm, 0);

    // Reset in the middle of a read shift, cs held low throughout
    cs = 1'b0; rwBit = 1'b1;
    cyc(1'b0, 1'b0);
    pulses(1'b1, W);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    pulses(1'b0, 4);
    chk("rst_pre_miso", int'(misoBufE), 1);
    reset = 1'b1;
    cyc(1'b0, 1'b0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_miso", int'(misoBufE), 0);
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    chk("rst_restart_busy", int'(busy), 1);
    cs = 1'b1;
    cyc(1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      if (cs) cs = ($urandom_range(0, 3) != 0);
      else    cs = ($urandom_range(0, 89) == 0);
      reset = ($urandom_range(0, 399) == 0);
      rwBit = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 5);
      cyc(r < 2, r == 2 || r == 3);
    end
    reset = 1'b0;
    cyc(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_transaction_fsm.md
SPI_TRANSACTION_FSM -- requirements
Module: spi_transaction_fsm

Interface
REQ-001 SHALL have parameter: width, 8, bits per SPI field (address+R/W field and data field).
REQ-002 SHALL have port: clk  input  1  FPGA clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: cs  input  1  conditioned chip select, active low.
REQ-005 SHALL have port: sclkPosEdge  input  1  one-clk pulse per SCLK rising edge.
REQ-006 SHALL have port: sclkNegEdge  input  1  one-clk pulse per SCLK falling edge.
REQ-007 SHALL have port: rwBit  input  1  shift-register parallel output bit 0 (1 = read, 0 = write).
REQ-008 SHALL have port: srLoad  output  1  shift-register parallelLoad strobe.
REQ-009 SHALL have port: addrWE  output  1  address-latch write enable.
REQ-010 SHALL have port: dmWE  output  1  data-memory write enable.
REQ-011 SHALL have port: misoBufE  output  1  MISO tri-state buffer enable.
REQ-012 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_MEM, DONE.
REQ-014 SHALL hold a bit counter of $clog2(width+1) bits, cleared on every state entry.
REQ-015 IDLE: cs low -> GET_ADDR next cycle; otherwise stay.
REQ-016 GET_ADDR: count sclkPosEdge pulses; on the cycle of the width-th pulse -> GOT_ADDR.
REQ-017 GOT_ADDR: addrWE=1 for exactly this one cycle; rwBit=1 -> READ_LOAD, rwBit=0 -> WRITE_GET.
REQ-018 READ_LOAD: srLoad=1 for exactly this one cycle; -> READ_SHIFT.
REQ-019 READ_SHIFT: misoBufE=1 every cycle in state; count sclkNegEdge; on width-th pulse -> DONE.
REQ-020 WRITE_GET: count sclkPosEdge; on width-th pulse -> WRITE_MEM.
REQ-021 WRITE_MEM: dmWE=1 for exactly this one cycle; -> DONE.
REQ-022 DONE: all strobes 0; stay until cs high, then -> IDLE.
REQ-023 cs high in any non-IDLE state SHALL force IDLE next cycle, overriding every other transition, including a simultaneous terminal edge.
REQ-024 Outputs SHALL be Moore (decoded from registered state only); srLoad, addrWE, dmWE never high in the same cycle.
REQ-025 Edge pulses in IDLE, GOT_ADDR, READ_LOAD, WRITE_MEM, DONE SHALL be ignored and not counted; sclkNegEdge ignored in counting-posedge states and vice versa.

Reset
REQ-026 reset high at posedge clk SHALL set state IDLE, counter 0, all outputs 0, overriding all inputs, including mid-transaction.
REQ-027 After reset deasserts, a still-low cs SHALL start a new transaction (IDLE -> GET_ADDR).

Configuration
REQ-028 Macro SPI_FSM_ABORT_ERR_EN defined: extra output port abortErr (output, 1 bit, reset 0) SHALL pulse one cycle on the cycle after cs-high forces IDLE from any state other than IDLE or DONE.
REQ-029 Macro SPI_FSM_ABORT_ERR_EN undefined: abortErr port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Write, width=8: cs low, 8 posedges with rwBit=0 at 8th -> addrWE one cycle; 8 more posedges -> dmWE one cycle next cycle; DONE until cs high; busy low the cycle after cs high.
REQ-031 Read: 8 posedges, rwBit=1 -> addrWE, then srLoad exactly one cycle later, then misoBufE high through exactly 8 negedges, low in DONE.
REQ-032 Abort: cs high after 3 address posedges -> IDLE next cycle, no addrWE/dmWE ever; with SPI_FSM_ABORT_ERR_EN abortErr=1 for one cycle.
REQ-033 Simultaneous: cs high on same cycle as 8th WRITE_GET posedge -> IDLE, dmWE never asserted.
REQ-034 Reset during READ_SHIFT after 4 negedges -> next cycle all outputs 0, busy 0; with cs still low, GET_ADDR one cycle later.
REQ-035 Noise: posedge and negedge pulses during DONE and while cs high -> no state change, no strobes.
